// File: rtl/conv_fprop_pkg.sv
// conv_fprop_pkg: width, saturation-bound and stage-range helpers shared by the conv_fprop multiplier pipeline
package conv_fprop_pkg;
  localparam int MIN_STAGE = 1;
  localparam int MAX_STAGE = 8;
  localparam int SAT_W = 256;
  function automatic int mul_pw(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction
  function automatic logic [SAT_W-1:0] sat_max(input int w);
    return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
  endfunction
  function automatic logic [SAT_W-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction
  function automatic bit stage_ok(input int n);
    return n >= MIN_STAGE && n <= MAX_STAGE;
  endfunction
endpackage

// File: rtl/conv_fprop_pipe_reg.sv
// conv_fprop_pipe_reg: one data+valid delay stage with clock enable and sync reset (clk, reset, ce_i, d_i, v_i -> d_o, v_o)
module conv_fprop_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  input  logic         v_i,
  output logic [W-1:0] d_o,
  output logic         v_o
);
  logic [W-1:0] d_q;
  logic v_q;
  always_ff @(posedge clk)
    if (reset) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else if (ce_i) begin
      d_q <= d_i;
      v_q <= v_i;
    end
  assign d_o = d_q;
  assign v_o = v_q;
endmodule

// File: rtl/conv_fprop_mul_pipe.sv
// conv_fprop_mul_pipe: pipelined multiplier with per-operand signedness, shift, saturate/truncate and a travelling valid (clk, reset, ce, din_valid, din0, din1 -> dout_valid, dout)
module conv_fprop_mul_pipe
  import conv_fprop_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 31,
  parameter int din1_WIDTH  = 32,
  parameter int dout_WIDTH  = 58,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int SHIFT       = 0,
  parameter int SATURATE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_valid,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_valid,
  output logic [dout_WIDTH-1:0] dout
);
  localparam int PW = mul_pw(din0_WIDTH, din1_WIDTH);
  localparam int EW = PW > dout_WIDTH ? PW : dout_WIDTH;
  localparam int K = NUM_STAGE == 1 ? 1 : 2;
  localparam bit STAGE_OK = stage_ok(NUM_STAGE);
  localparam logic [SAT_W-1:0] MAX_F = sat_max(dout_WIDTH);
  localparam logic [SAT_W-1:0] MIN_F = sat_min(dout_WIDTH);
  localparam logic signed [EW-1:0] MAX_V = MAX_F[EW-1:0];
  localparam logic signed [EW-1:0] MIN_V = MIN_F[EW-1:0];
  logic signed [din0_WIDTH:0] a_x;
  logic signed [din1_WIDTH:0] b_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] sh_src;
  logic signed [EW-1:0] p_s;
  logic [dout_WIDTH-1:0] res_d;
  logic [dout_WIDTH-1:0] st_data [K:NUM_STAGE];
  logic st_vld [K:NUM_STAGE];
  if (!STAGE_OK) begin : g_bad_stage
    $error("conv_fprop_mul_pipe %0d: NUM_STAGE %0d outside legal range", ID, NUM_STAGE);
  end
  // one extra bit per operand makes every signedness mix a plain signed multiply
  assign a_x = DIN0_SIGNED != 0 ? {din0[din0_WIDTH-1], din0} : {1'b0, din0};
  assign b_x = DIN1_SIGNED != 0 ? {din1[din1_WIDTH-1], din1} : {1'b0, din1};
  assign prod = PW'(a_x) * PW'(b_x);
  // widening to EW first gives sign extension when dout is wider than the product
  assign p_s = EW'(sh_src) >>> SHIFT;
  assign res_d = SATURATE != 0 && p_s > MAX_V ? MAX_V[dout_WIDTH-1:0] :
                 SATURATE != 0 && p_s < MIN_V ? MIN_V[dout_WIDTH-1:0] : p_s[dout_WIDTH-1:0];
  if (NUM_STAGE == 1) begin : g_s1
    logic [dout_WIDTH-1:0] r_q;
    logic v_q;
    assign sh_src = prod;
    always_ff @(posedge clk)
      if (reset) begin
        r_q <= '0;
        v_q <= 1'b0;
      end else if (ce) begin
        r_q <= res_d;
        v_q <= din_valid;
      end
    assign st_data[1] = r_q;
    assign st_vld[1] = v_q;
  end else begin : g_s2
    logic signed [PW-1:0] prod_q;
    logic v1_q;
    logic [dout_WIDTH-1:0] r_q;
    logic v2_q;
    assign sh_src = prod_q;
    always_ff @(posedge clk)
      if (reset) begin
        prod_q <= '0;
        v1_q <= 1'b0;
        r_q <= '0;
        v2_q <= 1'b0;
      end else if (ce) begin
        prod_q <= prod;
        v1_q <= din_valid;
        r_q <= res_d;
        v2_q <= v1_q;
      end
    assign st_data[2] = r_q;
    assign st_vld[2] = v2_q;
  end
  for (genvar s = 3; s <= NUM_STAGE; s++) begin : g_dly
    conv_fprop_pipe_reg #(.W(dout_WIDTH)) u_reg (
      .clk  (clk),
      .reset(reset),
      .ce_i (ce),
      .d_i  (st_data[s-1]),
      .v_i  (st_vld[s-1]),
      .d_o  (st_data[s]),
      .v_o  (st_vld[s])
    );
  end
  assign dout = st_data[NUM_STAGE];
  assign dout_valid = st_vld[NUM_STAGE];
endmodule

// File: tb/tb_conv_fprop_mul_pipe.sv
// tb_conv_fprop_mul_pipe: five parameter sets checked against an arithmetic reference every cycle plus hand-computed literals
module tb_conv_fprop_mul_pipe;
  localparam int NS  [5] = '{2, 2, 2, 2, 3};
  localparam int W0  [5] = '{31, 31, 31, 16, 8};
  localparam int W1  [5] = '{32, 32, 32, 16, 8};
  localparam int DW  [5] = '{58, 16, 16, 32, 16};
  localparam int S0  [5] = '{0, 0, 0, 1, 0};
  localparam int S1  [5] = '{1, 1, 1, 1, 0};
  localparam int SH  [5] = '{0, 0, 0, 4, 0};
  localparam int SAT [5] = '{0, 1, 0, 0, 0};
  logic clk = 1'b0;
  logic reset, ce, din_valid;
  logic [127:0] ra [5];
  logic [127:0] rb [5];
  logic [127:0] og [5];
  logic [4:0] ov;
  logic [127:0] hd [5][8];
  bit hv [5][8];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    logic [DW[g]-1:0] o;
    conv_fprop_mul_pipe #(
      .ID(g), .NUM_STAGE(NS[g]), .din0_WIDTH(W0[g]), .din1_WIDTH(W1[g]), .dout_WIDTH(DW[g]),
      .DIN0_SIGNED(S0[g]), .DIN1_SIGNED(S1[g]), .SHIFT(SH[g]), .SATURATE(SAT[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .din_valid (din_valid),
      .din0      (ra[g][W0[g]-1:0]),
      .din1      (rb[g][W1[g]-1:0]),
      .dout_valid(ov[g]),
      .dout      (o)
    );
    assign og[g] = 128'(o);
  end
  function automatic logic [127:0] mdl(int i, logic [127:0] ar, logic [127:0] br);
    logic signed [127:0] one, a, b, p, hi, lo;
    one = 1;
    a = ar & ((one << W0[i]) - 1);
    b = br & ((one << W1[i]) - 1);
    if (S0[i] != 0 && a[W0[i]-1]) a = a - (one << W0[i]);
    if (S1[i] != 0 && b[W1[i]-1]) b = b - (one << W1[i]);
    p = (a * b) >>> SH[i];
    hi = (one << (DW[i] - 1)) - 1;
    lo = -(one << (DW[i] - 1));
    if (SAT[i] != 0) p = p > hi ? hi : p < lo ? lo : p;
    return p & ((one << DW[i]) - 1);
  endfunction
  task automatic chk(string nm, logic [127:0] g, logic [127:0] w);
    n_chk++;
    if (g !== w) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, g, w, $time);
    end
  endtask
  task automatic lit(int i, bit v, logic [127:0] w);
    chk($sformatf("lit_valid%0d", i), 128'(ov[i]), 128'(v));
    chk($sformatf("lit_dout%0d", i), og[i], w);
  endtask
  task automatic set(int i, logic [127:0] a, logic [127:0] b);
    ra[i] = a;
    rb[i] = b;
  endtask
  task automatic rnd_inputs();
    for (int i = 0; i < 5; i++) set(i, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
  endtask
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (reset) begin
        for (int j = 0; j < 8; j++) begin
          hd[i][j] = '0;
          hv[i][j] = 1'b0;
        end
      end else if (ce) begin
        for (int j = 7; j > 0; j--) begin
          hd[i][j] = hd[i][j-1];
          hv[i][j] = hv[i][j-1];
        end
        hd[i][0] = mdl(i, ra[i], rb[i]);
        hv[i][0] = din_valid;
      end
      chk($sformatf("model_valid%0d", i), 128'(ov[i]), 128'(hv[i][NS[i]-1]));
      chk($sformatf("model_dout%0d", i), og[i], hd[i][NS[i]-1]);
    end
  end
  initial begin
    reset = 1'b1;
    ce = 1'b1;
    din_valid = 1'b0;
    for (int i = 0; i < 5; i++) set(i, 0, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) lit(i, 0, 0);
    reset = 1'b0;
    din_valid = 1'b1;
    set(0, 'h7FFFFFFF, -1);
    set(1, 1000, 1000);
    set(2, 1000, 1000);
    set(3, 100, -3);
    set(4, 255, 255);
    @(negedge clk);
    din_valid = 1'b0;
    set(1, 1000, -1000);
    set(2, 1000, -1000);
    set(3, 100, 3);
    set(4, 'h12, 'h34);
    @(negedge clk);
    lit(0, 1, 'h3FFFFFF80000001);
    lit(1, 1, 'h7FFF);
    lit(2, 1, 'h4240);
    lit(3, 1, 'hFFFFFFED);
    din_valid = 1'b1;
    set(4, 3, 5);
    @(negedge clk);
    lit(1, 0, 'h8000);
    lit(2, 0, 'hBDC0);
    lit(3, 0, 18);
    lit(4, 1, 65025);
    set(4, 200, 7);
    @(negedge clk);
    lit(4, 0, 'h3A8);
    din_valid = 1'b0;
    @(negedge clk);
    lit(4, 1, 15);
    @(negedge clk);
    lit(4, 1, 'h578);
    for (int k = 0; k < 20; k++) begin
      rnd_inputs();
      din_valid = k % 5 != 3;
      ce = !(k >= 6 && k < 11);
      @(negedge clk);
    end
    ce = 1'b1;
    din_valid = 1'b1;
    repeat (2) begin
      rnd_inputs();
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) lit(i, 0, 0);
    reset = 1'b0;
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    din_valid = 1'b1;
    repeat (2) begin
      rnd_inputs();
      @(negedge clk);
    end
    ce = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) lit(i, 0, 0);
    reset = 1'b0;
    ce = 1'b1;
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      rnd_inputs();
      din_valid = 1'($urandom_range(0, 1));
      ce = $urandom_range(0, 3) != 0;
      @(negedge clk);
    end
    ce = 1'b1;
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
